// File: rtl/pipe_drain_fifo_pkg.sv
// Shared widths, defaults and helpers for the pipeline drain FIFO.
// The skid default tracks the upstream microcode pipeline depth default.
package pipe_drain_fifo_pkg;

  localparam int DRAIN_FIFO_W_DEFAULT     = 32;
  localparam int DRAIN_FIFO_DEPTH_DEFAULT = 16;
  localparam int PIPE_N_DEFAULT           = 8;
  localparam int DRAIN_FIFO_SKID_DEFAULT  = PIPE_N_DEFAULT + 2;

  localparam int DRAIN_FIFO_AW = $clog2(DRAIN_FIFO_DEPTH_DEFAULT);

  typedef logic [DRAIN_FIFO_AW:0] ptr_t;
  typedef logic [DRAIN_FIFO_AW:0] level_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipe_drain_fifo_ptr.sv
// Wrap-bit read/write pointer pair for the drain FIFO; registered, 1-cycle update.
// Pure bookkeeping: callers gate the increments, so no backpressure handling here.
module pipe_drain_fifo_ptr
  import pipe_drain_fifo_pkg::*;
#(
  parameter int DEPTH = DRAIN_FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_inc,
  input  logic                     rd_inc,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Increment wraps naturally modulo 2*DEPTH; the MSB is the lap bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_inc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_inc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/pipe_drain_fifo.sv
// Captures the non-stallable pipeline output into a circular FIFO; out_vld 1 cycle after push, no fall-through.
// Consumer side is valid/accept; upstream is throttled by a registered stall from next-state free space.
module pipe_drain_fifo
  import pipe_drain_fifo_pkg::*;
#(
  parameter int W     = DRAIN_FIFO_W_DEFAULT,
  parameter int DEPTH = DRAIN_FIFO_DEPTH_DEFAULT,
  parameter int SKID  = DRAIN_FIFO_SKID_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           in,
  input  logic                   in_vld,
  output logic [W-1:0]           out,
  output logic                   out_vld,
  input  logic                   out_accept,
  output logic                   stall_r,
  output logic [$clog2(DEPTH):0] level_r,
  output logic                   overflow_r
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (!is_pow2(DEPTH) || (DEPTH < 4) || (SKID >= DEPTH)) begin : g_bad_params
    $fatal(1, "pipe_drain_fifo: DEPTH must be a power of 2 >= 4 and SKID < DEPTH");
  end

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            push_eff;
  logic            drop;
  logic [LW-1:0]   level_next;
  logic [LW-1:0]   free_next;

  assign push     = in_vld;
  assign pop      = out_vld & out_accept;
  // A pop frees the head slot this cycle, so a push into a full FIFO is still legal.
  assign push_eff = push & (~full | pop);
  assign drop     = push & full & ~pop;

  pipe_drain_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .wr_inc (push_eff),
    .rd_inc (pop),
    .wr_idx (wr_idx),
    .rd_idx (rd_idx),
    .empty  (empty),
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_idx] <= in;
  end

  assign out     = mem[rd_idx];
  assign out_vld = ~empty;

  always_comb begin
    level_next = level_r + LW'(push_eff) - LW'(pop);
    free_next  = LW'(DEPTH) - level_next;
  end

  // Stall is judged on next-state free space so the register delay is already covered by SKID.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r    <= '0;
      stall_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      level_r <= level_next;
      stall_r <= (free_next < LW'(SKID));
      if (drop) overflow_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Directed bench for pipe_drain_fifo: stimulus queues expected data, a negedge monitor checks every pop.
module tb_pipe_drain_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] in;
  logic        in_vld;
  logic [31:0] out;
  logic        out_vld;
  logic        out_accept;
  logic        stall_r;
  logic [4:0]  level_r;
  logic        overflow_r;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_head;

  pipe_drain_fifo #(
    .W     (32),
    .DEPTH (16),
    .SKID  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_vld     (in_vld),
    .out        (out),
    .out_vld    (out_vld),
    .out_accept (out_accept),
    .stall_r    (stall_r),
    .level_r    (level_r),
    .overflow_r (overflow_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every handshake the DUT completes must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_vld && out_accept) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_underflow actual=%08h required=<no entry expected>", out);
      end else begin
        exp_head = exp_q.pop_front();
        if (out !== exp_head) begin
          errors++;
          $display("FAIL pop_data actual=%08h required=%08h", out, exp_head);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input logic p, input logic [31:0] d, input logic a, input logic dropped);
    in_vld     = p;
    in         = d;
    out_accept = a;
    if (p && !dropped) exp_q.push_back(d);
    @(posedge clk);
    #1;
    in_vld     = 1'b0;
    out_accept = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_vld     = 1'b0;
    out_accept = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in         = '0;
    in_vld     = 1'b0;
    out_accept = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_level", 32'(level_r), 32'd0);
    chk("rst_stall", 32'(stall_r), 32'd0);
    chk("rst_overflow", 32'(overflow_r), 32'd0);

    // Single push, then accept with nothing left: stray accept is ignored.
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("t1_out_vld", 32'(out_vld), 32'd1);
    chk("t1_out", out, 32'hDEAD_BEEF);
    chk("t1_level", 32'(level_r), 32'd1);
    chk("t1_stall", 32'(stall_r), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_idle_level", 32'(level_r), 32'd0);
    chk("t1_idle_overflow", 32'(overflow_r), 32'd0);

    // Fill to full: stall rises once level reaches 7 (free 9 < 10).
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 32'(k), 1'b0, 1'b0);
      chk($sformatf("t2_fill_stall_%0d", k), 32'(stall_r), 32'(k >= 6));
    end
    chk("t2_level_full", 32'(level_r), 32'd16);
    chk("t2_overflow", 32'(overflow_r), 32'd0);
    for (int j = 0; j < 16; j++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("t2_drain_stall_%0d", j), 32'(stall_r), 32'(j <= 8));
    end
    chk("t2_empty", 32'(out_vld), 32'd0);

    // Full with simultaneous push and pop.
    for (int k = 0; k < 16; k++) step(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
    chk("t3_level", 32'(level_r), 32'd16);
    chk("t3_overflow", 32'(overflow_r), 32'd0);
    chk("t3_head", out, 32'h101);
    for (int j = 0; j < 16; j++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_drained", 32'(level_r), 32'd0);

    // Full with push and no pop: data dropped, overflow sticks.
    for (int k = 0; k < 16; k++) step(1'b1, 32'h200 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'h0000_0BAD, 1'b0, 1'b1);
    chk("t4_overflow", 32'(overflow_r), 32'd1);
    chk("t4_level", 32'(level_r), 32'd16);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t4_overflow_sticky", 32'(overflow_r), 32'd1);
    for (int j = 0; j < 16; j++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_overflow_after_drain", 32'(overflow_r), 32'd1);
    chk("t4_empty", 32'(out_vld), 32'd0);

    // Streaming push+pop: level holds at 1 while pointers lap twice.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      chk($sformatf("t5_level_%0d", i), 32'(level_r), 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_empty", 32'(out_vld), 32'd0);

    // Mid-stream reset with stall asserted.
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b1, 32'h500 + 32'(k), 1'b0, 1'b0);
    chk("t6_level_pre", 32'(level_r), 32'd12);
    chk("t6_stall_pre", 32'(stall_r), 32'd1);
    do_reset();
    chk("t6_level", 32'(level_r), 32'd0);
    chk("t6_out_vld", 32'(out_vld), 32'd0);
    chk("t6_stall", 32'(stall_r), 32'd0);
    chk("t6_overflow", 32'(overflow_r), 32'd0);
    step(1'b1, 32'h0000_600D, 1'b0, 1'b0);
    chk("t6_out", out, 32'h0000_600D);
    chk("t6_level_post", 32'(level_r), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_empty", 32'(out_vld), 32'd0);

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_drain_fifo.md
Name: pipe_drain_fifo

Overview:
- Sits directly downstream of the stallable microcode pipeline. Captures its output stream, which carries a valid but has no backpressure.
- Buffers entries in a DEPTH-entry circular FIFO and presents them to the consumer on a valid/accept handshake.
- Drives a registered stall request back into the pipeline's final stall_req bit. This keeps the in-flight entries from overflowing the buffer.

Parameters:
- W, 32, data width; must equal the upstream pipeline W.
- DEPTH, 16, FIFO entries; power of 2, at least 4.
- SKID, 10, free-slot threshold for stall; must be at least the upstream pipeline depth N plus 1, and less than DEPTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in  input  W  data from the upstream pipeline output register
- in_vld  input  1  upstream output valid; always accepted, no backpressure
- out  output  W  head-of-FIFO data
- out_vld  output  1  FIFO non-empty
- out_accept  input  1  consumer takes the head this cycle
- stall_r  output  1  registered stall request to the upstream pipeline's last stall_req bit
- level_r  output  $clog2(DEPTH)+1  current occupancy
- overflow_r  output  1  sticky error, push attempted while full with no pop

Behaviour:
- Reset (rst=1 at posedge): pointers=0, level_r=0, stall_r=0, overflow_r=0.
  - Outputs after reset: out_vld=0; out is don't-care.
  - Storage array is not reset. Reset mid-stream discards all contents in one cycle.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, where the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - Increment is modulo 2*DEPTH; natural wrap, no special case.
- push = in_vld. pop = out_vld & out_accept.
- out_accept while out_vld=0 is ignored: no pointer move, no error.
- Write: on push & (~full | pop), mem[wr_ptr idx] <= in and wr_ptr++.
  - Push and pop together while full is legal. The write lands in the slot being freed; the read returns the old head this cycle.
- Read: out = mem[rd_ptr idx], a combinational read of the flop array. out_vld = ~empty. pop advances rd_ptr.
- Latency: in_vld at cycle t gives out_vld=1 at t+1 if the FIFO was empty. Fall-through is not permitted (no combinational in→out path).
- Overflow: push & full & ~pop sets overflow_r=1 at the next edge and drops the data. overflow_r clears only on rst.
- level_r: next = level + push_eff − pop, where push_eff is the write actually performed. Range 0..DEPTH.
- Stall:
  - stall_r <= ((DEPTH − level_next) < SKID), registered from next-state occupancy.
  - One cycle of register delay plus up to N−1 in-flight upstream entries are covered by SKID ≥ N+1. Overflow is therefore unreachable when the parameters are legal.
- Simultaneous events:
  - push+pop on empty: write occurs, head unchanged (empty) this cycle, out_vld=1 next cycle.
  - push+pop on non-full: level unchanged.
- Parameter legality: SKID ≥ DEPTH or DEPTH not a power of 2 is a static elaboration error, implemented as a generate-time $fatal.

Decomposition:
- Shared package: ptr_t / level_t typedef widths derived from DEPTH, and a DRAIN_FIFO_SKID_DEFAULT constant aligned with the pipeline N default.
- Natural sub-module: pipe_drain_fifo_ptr, a wrap-bit pointer counter with inc enable and empty/full compare. It is instantiated twice (wr, rd) or used once for the compare.
- Storage is an inline flop array, not a separate module.

Test Plan:
All directed tests use W=32, DEPTH=16, SKID=10.
1. Reset, then one push of 0xDEAD_BEEF with out_accept=0 → out_vld=1 at t+1, out=0xDEADBEEF, level_r=1, stall_r=0.
2. Push 0..15 on consecutive cycles with out_accept=0.
   - Expect stall_r=1 from the edge where level_next=7 (free=9<10).
   - Expect level_r=16 and overflow_r=0.
   - Drain with out_accept=1 → values 0..15 in order. stall_r drops once level_next ≤ 6.
3. Full FIFO with push (0xA5) and out_accept both high → out=old head, level_r stays 16, overflow_r=0, 0xA5 appears last on drain.
4. Full FIFO, push with out_accept=0 → overflow_r=1 next cycle and stays 1. Drained data excludes the dropped value.
5. Continuous push+pop for 40 cycles with values 0..39 → pointers wrap twice, out sequence 0..39 with 1-cycle lag, level_r constant at 1.
6. Assert rst with level_r=12 and stall_r=1 → next cycle level_r=0, out_vld=0, stall_r=0, overflow_r=0. A push on the following cycle is output correctly.
